// File: rtl/adel_pkg.sv
// Shared definitions for the adel core and its instruction-fetch neighbour:
// default NOP word, loader state encoding and instruction field positions.
package adel_pkg;

    localparam logic [15:0] NOP_INST = 16'hE000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        RUN
    } loader_state_t;

    // Instruction field positions, shared with the core's decoder
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 7;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/adel_imem.sv
// DEPTH x 16 instruction store: async reset to NOP, one synchronous write port
// and one combinational read port that returns NOP for any out-of-range pc.
module adel_imem
    import adel_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter logic [15:0] NOP_WORD = NOP_INST,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [15:0]   pc,
    output logic [15:0]   inst
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_WORD;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The full pc is range-checked so high addresses never alias onto low words
    assign inst = (pc < 16'(DEPTH)) ? mem[pc[AW-1:0]] : NOP_WORD;

endmodule

// File: rtl/adel_imem_loader.sv
// Instruction memory plus byte-stream program loader for the adel core; keeps
// the core in reset until a complete program has been written.
module adel_imem_loader
    import adel_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter logic [15:0] NOP_WORD = NOP_INST,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          load_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    input  logic [15:0]   pc,
    output logic [15:0]   inst,
    output logic          core_nrst,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   load_words
);

    loader_state_t state;
    logic [7:0]    lo_byte;
    logic [AW:0]   waddr;
    logic          accept;
    logic          in_range;
    logic          wr_en;

    // load_start takes priority, so a byte offered in the same cycle is refused
    assign ld_ready   = ((state == LOAD_LO) || (state == LOAD_HI)) && !load_start;
    assign accept     = ld_valid && ld_ready;
    assign in_range   = waddr < (AW + 1)'(DEPTH);
    assign wr_en      = accept && (state == LOAD_HI) && in_range;
    assign load_words = waddr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            lo_byte   <= 8'h00;
            waddr     <= '0;
            core_nrst <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                state     <= LOAD_LO;
                lo_byte   <= 8'h00;
                waddr     <= '0;
                load_err  <= 1'b0;
                core_nrst <= 1'b0;
            end else begin
                case (state)
                    LOAD_LO: begin
                        if (accept) begin
                            lo_byte <= ld_data;
                            state   <= LOAD_HI;
                        end
                    end
                    LOAD_HI: begin
                        if (accept) begin
                            // Overflowing words are still accepted so the stream never stalls
                            if (in_range) begin
                                waddr <= waddr + 1'b1;
                            end else begin
                                load_err <= 1'b1;
                            end
                            if (ld_last) begin
                                state     <= RUN;
                                load_done <= 1'b1;
                                core_nrst <= 1'b1;
                            end else begin
                                state <= LOAD_LO;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    adel_imem #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP_WORD)
    ) u_imem (
        .clk   (clk),
        .nrst  (nrst),
        .we    (wr_en),
        .waddr (waddr[AW-1:0]),
        .wdata ({ld_data, lo_byte}),
        .pc    (pc),
        .inst  (inst)
    );

endmodule
